swn: RTL

Parametrised N-port input-buffered packet switch, the successor to the fixed 4-way `sw`. Each input port has a DEPTH-entry FIFO. Each output port has a round-robin arbiter, and a registered crossbar drives the outputs. New over `sw`: configurable port count, packet width and buffer depth; per-output hold (backpressure) from downstream; a per-input full flag to upstream. Sits between the link receivers and transmitters as the core switching element.

---
 rtl/swn_pkg.sv | 23 ++
 rtl/swn_if.sv | 16 +
 rtl/swn_ib.sv | 66 ++++++
 rtl/swn.sv | 101 ++++++++++
 4 files changed

// File: rtl/swn_pkg.sv
// Shared definitions for the swn packet switch: default configuration,
// destination-field width and valid-bit helpers, and the all-zero packet.
package swn_pkg;

  localparam int SWN_NPORT = 4;
  localparam int SWN_PKTW  = 16;
  localparam int SWN_DEPTH = 4;

  // Width of the destination field for a given port count.
  function automatic int dst_w(input int nport);
    return (nport > 1) ? $clog2(nport) : 1;
  endfunction

  // Index of the valid bit inside a packet word.
  function automatic int vbit(input int pktw);
    return pktw - 1;
  endfunction

  localparam int SWN_DSTW = dst_w(SWN_NPORT);

  localparam logic [SWN_PKTW-1:0] SWN_ZERO_PKT = '0;

endpackage

// File: rtl/swn_if.sv
// Packet bus between the switch core and its link receivers/transmitters.
// The slave side is the switch; the master side is the surrounding link logic.
interface swn_if
  import swn_pkg::*;
#(
  parameter int NPORT = SWN_NPORT,
  parameter int PKTW  = SWN_PKTW
);
  logic [NPORT*PKTW-1:0] i;
  logic [NPORT*PKTW-1:0] o;
  logic [NPORT-1:0]      full;
  logic [NPORT-1:0]      ohold;

  modport master (output i, output ohold, input o, input full);
  modport slave  (input i, input ohold, output o, output full);
endinterface

// File: rtl/swn_ib.sv
// Per-input circular-buffer FIFO. Full is registered from the post-update
// count, so a word arriving while full is dropped even if a pop happens
// on the same edge.
module swn_ib
  import swn_pkg::*;
#(
  parameter int PKTW  = SWN_PKTW,
  parameter int DEPTH = SWN_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PKTW-1:0] din,
  output logic [PKTW-1:0] head,
  output logic            empty,
  output logic            full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PKTW-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CW'(1);
    end else if (do_pop && !do_push) begin
      count_next = count - CW'(1);
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, count and the registered full flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
    end
  end
endmodule

// File: rtl/swn.sv
// N-port input-buffered switch core: one FIFO per input, a round-robin
// arbiter per output and a registered crossbar. Only FIFO heads request,
// so head-of-line blocking is accepted by design.
module swn
  import swn_pkg::*;
#(
  parameter int NPORT = SWN_NPORT,
  parameter int PKTW  = SWN_PKTW,
  parameter int DEPTH = SWN_DEPTH
) (
  input logic   clk,
  input logic   rst,
  swn_if.slave  bus
);
  localparam int DSTW = dst_w(NPORT);
  localparam int VBIT = vbit(PKTW);

  logic [PKTW-1:0]  head [NPORT];
  logic [NPORT-1:0] empty;
  logic [NPORT-1:0] full_v;
  logic [NPORT-1:0] pop;
  logic [NPORT-1:0] req [NPORT];
  logic [NPORT-1:0] gnt_any;
  logic [DSTW-1:0]  gnt_idx [NPORT];

  for (genvar k = 0; k < NPORT; k++) begin : g_in
    logic [PKTW-1:0] din;
    assign din = bus.i[k*PKTW +: PKTW];

    swn_ib #(.PKTW(PKTW), .DEPTH(DEPTH)) u_ib (
      .clk   (clk),
      .rst   (rst),
      .push  (din[VBIT]),
      .pop   (pop[k]),
      .din   (din),
      .head  (head[k]),
      .empty (empty[k]),
      .full  (full_v[k])
    );
  end

  assign bus.full = full_v;

  // Request matrix: req[j][k] means the head of FIFO k wants output j.
  always_comb begin
    for (int j = 0; j < NPORT; j++) begin
      req[j] = '0;
      for (int k = 0; k < NPORT; k++) begin
        req[j][k] = !empty[k] && (head[k][DSTW-1:0] == DSTW'(j));
      end
    end
  end

  // A granted input pops its head; each input targets one output at most.
  always_comb begin
    pop = '0;
    for (int j = 0; j < NPORT; j++) begin
      if (gnt_any[j]) pop[gnt_idx[j]] = 1'b1;
    end
  end

  for (genvar j = 0; j < NPORT; j++) begin : g_out
    logic [DSTW-1:0] ptr;
    logic [DSTW-1:0] cand;
    logic [DSTW-1:0] idx;
    logic            any;
    logic [PKTW-1:0] o_q;

    // Round-robin search starting one past the last granted input.
    always_comb begin
      any  = 1'b0;
      idx  = ptr;
      cand = ptr;
      if (!bus.ohold[j]) begin
        for (int off = 1; off <= NPORT; off++) begin
          cand = ptr + DSTW'(off);
          if (!any && req[j][cand]) begin
            any = 1'b1;
            idx = cand;
          end
        end
      end
    end

    assign gnt_any[j] = any;
    assign gnt_idx[j] = idx;

    // Pointer update and crossbar output register for this output.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ptr <= DSTW'(NPORT - 1);
        o_q <= PKTW'(SWN_ZERO_PKT);
      end else begin
        if (any) ptr <= idx;
        o_q <= any ? head[idx] : PKTW'(SWN_ZERO_PKT);
      end
    end

    assign bus.o[j*PKTW +: PKTW] = o_q;
  end
endmodule
